// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : conv_line_buffer
// Brief    : Two-line buffer that turns a raster pixel stream into 3-row columns
// Revision : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [DATA_W-1:0]     i_data,
  output logic                  o_valid,
  output logic                  o_img_done,
  output logic [3*DATA_W-1:0]   o_col
);

  localparam int c_COL_W = $clog2(IMG_WIDTH);
  localparam int c_ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);

  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t               state_q;
  logic [c_COL_W-1:0]   col_q;
  logic [c_ROW_W-1:0]   row_q;
  logic                 w_col_last;
  logic                 w_row_last;

  logic [DATA_W-1:0]    line_a_mem [IMG_WIDTH];
  logic [DATA_W-1:0]    line_b_mem [IMG_WIDTH];
  logic [DATA_W-1:0]    a_rd_q;
  logic [DATA_W-1:0]    b_rd_q;

  logic                 s1_wr_q;
  logic                 s1_emit_q;
  logic                 s1_last_q;
  logic [DATA_W-1:0]    s1_data_q;
  logic [c_COL_W-1:0]   s1_col_q;

  assign w_col_last = (col_q == c_COL_LAST);
  assign w_row_last = (row_q == c_ROW_LAST);

  // Raster position and fill/stream state advance only on accepted pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= ST_FILL;
    end else if (i_valid) begin
      if (w_col_last) begin
        col_q <= '0;
        row_q <= w_row_last ? '0 : row_q + c_ROW_ONE;
      end else begin
        col_q <= col_q + c_COL_W'(1);
      end
      case (state_q)
        ST_FILL:   if (w_col_last && row_q == c_ROW_ONE) state_q <= ST_STREAM;
        ST_STREAM: if (w_col_last && w_row_last)        state_q <= ST_FILL;
        default:                                         state_q <= ST_FILL;
      endcase
    end
  end

  // Read-before-write: lineA returns the old row while taking the new pixel;
  // that old value shifts into lineB one cycle later at the same column.
  always_ff @(posedge clk) begin
    if (i_valid) begin
      a_rd_q           <= line_a_mem[col_q];
      b_rd_q           <= line_b_mem[col_q];
      line_a_mem[col_q] <= i_data;
    end
    if (s1_wr_q) begin
      line_b_mem[s1_col_q] <= a_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_wr_q   <= 1'b0;
      s1_emit_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_data_q <= '0;
      s1_col_q  <= '0;
    end else begin
      s1_wr_q   <= i_valid;
      s1_emit_q <= i_valid && (state_q == ST_STREAM);
      s1_last_q <= w_col_last && w_row_last;
      if (i_valid) begin
        s1_data_q <= i_data;
        s1_col_q  <= col_q;
      end
    end
  end

  // o_col holds its last value between valid columns.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid    <= 1'b0;
      o_img_done <= 1'b0;
      o_col      <= '0;
    end else begin
      o_valid    <= s1_emit_q;
      o_img_done <= s1_emit_q && s1_last_q;
      if (s1_emit_q) begin
        o_col <= {s1_data_q, a_rd_q, b_rd_q};
      end
    end
  end

endmodule
`default_nettype wire
